pwm_from_count: RTL

PWM_FROM_COUNT -- requirements
Module: pwm_from_count

---
 rtl/pwm_pkg.sv | 15 +
 rtl/duty_shadow.sv | 44 ++++
 rtl/pwm_from_count.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM stages: controller state encoding and
// the default count/duty width.
package pwm_pkg;

    // Default width of the upstream count and of the duty value.
    localparam int PWM_WIDTH = 4;

    // SYNC: waiting for COUNT==0 to lock onto the period.
    // RUN : locked; COUNT is checked for +1 steps every cycle.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/duty_shadow.sv
// Single-entry valid/ready holding slot for a duty value. A value is
// accepted when the slot is empty and released when the consumer pulses
// i_take. o_ready depends only on the slot register, so there is no
// combinational path from i_valid to o_ready.
module duty_shadow #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_take,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    assign o_ready  = ~r_full;
    assign w_accept = i_valid & ~r_full;
    assign o_full   = r_full;
    assign o_data   = r_data;

    // Slot state: capture on handshake, empty on take, clear on reset.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so ordering inside the block cannot create races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            // A handshake in the same cycle as a take wins: the new value
            // stays in the slot for the following release.
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

endmodule : duty_shadow

// File: rtl/pwm_from_count.sv
// PWM generator slaved to an external free-running counter. The block
// locks onto COUNT==0 as the period start, verifies that COUNT steps by
// one every cycle, and drives O high while COUNT is below the duty that
// was active at the most recent period start. New duty values pass
// through a one-deep valid/ready slot and take effect at a boundary.
module pwm_from_count
    import pwm_pkg::*;
#(
    parameter int               WIDTH     = PWM_WIDTH,
    parameter logic [WIDTH-1:0] INIT_DUTY = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] COUNT,
    input  logic [WIDTH-1:0] DUTY,
    input  logic             DUTY_VALID,
    output logic             DUTY_READY,
    output logic             O,
    output logic             PERIOD,
    output logic             ERR
);

    // Controller state
    pwm_state_e       r_state;
    pwm_state_e       w_next_state;

    // Count tracking
    logic [WIDTH-1:0] r_prev_count;
    logic [WIDTH-1:0] w_count_expected;
    logic             w_count_zero;
    logic             w_boundary;
    logic             w_seq_err;

    // Duty datapath
    logic [WIDTH-1:0] r_active_duty;
    logic [WIDTH-1:0] w_eff_duty;
    logic [WIDTH-1:0] w_pend_data;
    logic             w_pend_full;
    logic             w_load;

    // Registered outputs and their next values
    logic             r_o;
    logic             r_period;
    logic             r_err;
    logic             w_o_next;
    logic             w_period_next;
    logic             w_err_next;

    // Wraps modulo 2^WIDTH, matching the upstream counter.
    assign w_count_expected = r_prev_count + 1'b1;
    assign w_count_zero     = (COUNT == '0);

    // Pending-duty slot; released into active_duty at a boundary.
    duty_shadow #(
        .WIDTH (WIDTH)
    ) u_duty_shadow (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_valid (DUTY_VALID),
        .i_data  (DUTY),
        .i_take  (w_load),
        .o_ready (DUTY_READY),
        .o_full  (w_pend_full),
        .o_data  (w_pend_data)
    );

    // A boundary with a full slot swaps in the pending duty; that value
    // already governs the boundary cycle itself.
    assign w_load     = w_boundary & w_pend_full;
    assign w_eff_duty = w_load ? w_pend_data : r_active_duty;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, period-boundary and sequence-error detection.
    // NOTE: every signal gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_boundary   = 1'b0;
        w_seq_err    = 1'b0;
        unique case (r_state)
            SYNC: begin
                if (w_count_zero) begin
                    w_next_state = RUN;
                    w_boundary   = 1'b1;
                end
            end
            RUN: begin
                if (COUNT != w_count_expected) begin
                    // A broken sequence cannot be trusted as a boundary.
                    w_seq_err    = 1'b1;
                    w_next_state = SYNC;
                end else if (w_count_zero) begin
                    w_boundary   = 1'b1;
                end
            end
            default: begin
                w_next_state = SYNC;
            end
        endcase
    end

    // Output decode: PWM level, period marker and sticky error.
    always_comb begin
        w_o_next      = (w_next_state == RUN) && (COUNT < w_eff_duty);
        w_period_next = w_boundary;
        w_err_next    = r_err | w_seq_err;
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_o      <= 1'b0;
            r_period <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_o      <= w_o_next;
            r_period <= w_period_next;
            r_err    <= w_err_next;
        end
    end

    // Count history (every cycle, any state) and active duty update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev_count  <= '0;
            r_active_duty <= INIT_DUTY;
        end else begin
            r_prev_count <= COUNT;
            if (w_load) begin
                r_active_duty <= w_pend_data;
            end
        end
    end

    assign O      = r_o;
    assign PERIOD = r_period;
    assign ERR    = r_err;

endmodule : pwm_from_count
